// File: rtl/z_depth_store.sv
// Z-buffer depth memory: word-addressed read/write responder with base-relative
// indexing, sticky out-of-range flag and a one-entry-per-cycle hardware fast-clear.
module z_depth_store #(
  parameter int Z_SIZE    = 8,
  parameter int X_RES     = 4,
  parameter int Y_RES     = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DEPTH     = X_RES * Y_RES,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE-1:0] base_address_i,
  input  logic                 buf_r_w,
  input  logic [ADDR_SIZE-1:0] buf_addr,
  input  logic [Z_SIZE-1:0]    buf_data_w,
  output logic [Z_SIZE-1:0]    buf_data_r,
  input  logic                 data_r_ready,
  output logic                 data_r_valid,
  input  logic                 data_w_valid,
  output logic                 data_w_ready,
  input  logic                 clear_i,
  input  logic [Z_SIZE-1:0]    clear_value_i,
  output logic                 clear_busy_o,
  output logic                 clear_done_o,
  output logic                 addr_err_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_LOOKUP = 3'd1;
  localparam logic [2:0] RD_RESP   = 3'd2;
  localparam logic [2:0] WR_ACK    = 3'd3;
  localparam logic [2:0] CLEAR     = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [Z_SIZE-1:0] mem [DEPTH];

  logic [2:0]        state_q,   state_d;
  logic              oor_q,     oor_d;
  logic [IDX_W-1:0]  cnt_q,     cnt_d;
  logic [Z_SIZE-1:0] clr_val_q, clr_val_d;
  logic [Z_SIZE-1:0] rdata_q,   rdata_d;
  logic              rvalid_q,  rvalid_d;
  logic              wready_q,  wready_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;
  logic [Z_SIZE-1:0] mem_rd_q;

  logic [ADDR_SIZE-1:0] req_idx;
  logic                 req_inr;
  logic                 mem_we;
  logic                 mem_re;
  logic [IDX_W-1:0]     mem_waddr;
  logic [Z_SIZE-1:0]    mem_wdata;

  // Modular subtract: addresses below the base wrap to huge indices and fail the range test.
  assign req_idx = buf_addr - base_address_i;
  assign req_inr = (req_idx < ADDR_SIZE'(DEPTH));

  always_comb begin
    state_d   = state_q;
    oor_d     = oor_q;
    cnt_d     = cnt_q;
    clr_val_d = clr_val_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    wready_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = req_idx[IDX_W-1:0];
    mem_wdata = buf_data_w;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d   = CLEAR;
          clr_val_d = clear_value_i;
          cnt_d     = '0;
          busy_d    = 1'b1;
          err_d     = 1'b0;
        end else if (data_w_valid && !buf_r_w) begin
          state_d  = WR_ACK;
          wready_d = 1'b1;
          mem_we   = req_inr;
          if (!req_inr) err_d = 1'b1;
        end else if (buf_r_w && data_r_ready) begin
          state_d = RD_LOOKUP;
          mem_re  = 1'b1;
          oor_d   = !req_inr;
          if (!req_inr) err_d = 1'b1;
        end
      end
      RD_LOOKUP: begin
        state_d  = RD_RESP;
        rdata_d  = oor_q ? {Z_SIZE{1'b1}} : mem_rd_q;
        rvalid_d = 1'b1;
      end
      RD_RESP: begin
        if (data_r_ready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      WR_ACK: state_d = IDLE;
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = clr_val_q;
        cnt_d     = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      oor_q     <= 1'b0;
      cnt_q     <= '0;
      clr_val_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      wready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      oor_q     <= oor_d;
      cnt_q     <= cnt_d;
      clr_val_q <= clr_val_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      wready_q  <= wready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Storage is deliberately not reset; contents are defined by the first clear.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rd_q <= mem[req_idx[IDX_W-1:0]];
  end

  assign buf_data_r   = rdata_q;
  assign data_r_valid = rvalid_q;
  assign data_w_ready = wready_q;
  assign clear_busy_o = busy_q;
  assign clear_done_o = done_q;
  assign addr_err_o   = err_q;

endmodule

// File: doc/z_depth_store.md
# z_depth_store

On-chip depth memory for the rasteriser: the responder on the z-buffer memory port (buf_r_w / buf_addr / buf_data_w / buf_data_r with read and write valid/ready pairs). It holds one Z_SIZE depth word per pixel, answers single-word depth reads and writes from the depth-test block, and provides a hardware fast-clear of the whole buffer. It translates byte-free word addresses relative to a programmable base into a local index and flags out-of-range accesses.

## Interface
Parameters:
- Z_SIZE, 8, depth word width
- X_RES, 4, pixels per row
- Y_RES, 4, rows
- ADDR_SIZE, 32, address width
- DEPTH, X_RES*Y_RES, entries (derived)
- IDX_W, $clog2(DEPTH), index width (derived)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- base_address_i  in  ADDR_SIZE  word address of entry 0
- buf_r_w  in  1  1 = read request, 0 = write request
- buf_addr  in  ADDR_SIZE  request word address
- buf_data_w  in  Z_SIZE  write data
- buf_data_r  out  Z_SIZE  read data
- data_r_ready  in  1  initiator requests/accepts read data
- data_r_valid  out  1  read data valid
- data_w_valid  in  1  write request valid
- data_w_ready  out  1  write accepted
- clear_i  in  1  start fast-clear (pulse)
- clear_value_i  in  Z_SIZE  fill value, sampled with clear_i
- clear_busy_o  out  1  fast-clear in progress
- clear_done_o  out  1  one-cycle pulse at clear completion
- addr_err_o  out  1  sticky out-of-range flag

## Operation
- idx = buf_addr - base_address_i (ADDR_SIZE modular subtract); in range iff idx < DEPTH; memory indexed with idx[IDX_W-1:0].
- States: IDLE, RD_LOOKUP, RD_RESP, WR_ACK, CLEAR.
- IDLE priority when several requests present: clear_i > write (data_w_valid && !buf_r_w) > read (buf_r_w && data_r_ready).
- Read: IDLE->RD_LOOKUP latches idx, synchronous RAM read. RD_LOOKUP->RD_RESP. In RD_RESP data_r_valid=1, buf_data_r=mem[idx] (or all-ones if out of range), held stable until data_r_valid && data_r_ready, then ->IDLE with data_r_valid=0.
- Write: on IDLE->WR_ACK edge mem[idx] <= buf_data_w (discarded if out of range). WR_ACK drives data_w_ready=1 for exactly one cycle, then ->IDLE. Write commits once even if data_w_valid drops during WR_ACK.
- Out-of-range read or write sets addr_err_o; cleared only by rst_i or clear_i acceptance.
- Clear: IDLE->CLEAR latches clear_value_i, counter=0; one entry written per cycle, counter 0..DEPTH-1; after writing DEPTH-1 ->IDLE, clear_done_o=1 for that one cycle. clear_busy_o=1 throughout CLEAR. No read/write serviced (data_r_valid=data_w_ready=0); clear_i during CLEAR ignored.
- Reset (any state, incl. mid-clear or mid-read): state IDLE, buf_data_r=0, data_r_valid=0, data_w_ready=0, clear_busy_o=0, clear_done_o=0, addr_err_o=0, counter=0. Memory contents not reset (undefined until first clear).

## Timing
- Read latency: request sampled at edge T, data_r_valid high in cycle T+2; with data_r_ready held high, handshake completes at end of T+2; next request sampled no earlier than edge T+3.
- Write: sampled at edge T, data_w_ready high in cycle T+1 only; back-to-back writes every 2 cycles (a held data_w_valid with new address is re-sampled in IDLE at T+2).
- Clear: DEPTH+1 cycles from clear_i sampling to return to IDLE; clear_busy_o high for DEPTH cycles.
- All outputs registered; no combinational path input->output.

## Test plan
- Reset, clear_i with clear_value_i=8'hFF, base=0x100 -> clear_busy_o high 16 cycles, clear_done_o single pulse, then reads of 0x100..0x10F return 8'hFF.
- Write 8'h3C to 0x105, read 0x105 -> data_w_ready one cycle at T+1; data_r_valid at T+2 with buf_data_r=8'h3C; other entries still 8'hFF.
- Read 0x10A with data_r_ready dropped in RD_RESP for 3 cycles -> data_r_valid and buf_data_r held until ready returns, single handshake.
- Write to 0x0FF and 0x110 -> acknowledged, memory unchanged, addr_err_o sets and stays 1; read 0x110 returns 8'hFF; subsequent clear_i clears addr_err_o.
- Simultaneous clear_i and write request in IDLE -> clear wins, write not acked until clear completes, then write lands and is read back after clear value.
- rst_i asserted mid-clear (counter=7) -> next cycle all outputs at reset values, state IDLE, no clear_done_o pulse; new clear completes normally.
